// File: rtl/amdc_gpio_bank_pkg.sv
// rtl/amdc_gpio_bank_pkg.sv - shared constants, FSM states and helpers for the GPIO bank
package amdc_gpio_bank_pkg;

  // Word indices (byte address [4:2]) of the register map
  localparam logic [2:0] REG_OUT      = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_RISE     = 3'd3;
  localparam logic [2:0] REG_FALL     = 3'd4;
  localparam logic [2:0] REG_IRQ_EN   = 3'd5;
  localparam logic [2:0] REG_CONFIG   = 3'd6;

  localparam logic [15:0] VERSION   = 16'h0200;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/amdc_gpio_bank_sync.sv
// rtl/amdc_gpio_bank_sync.sv - per-pin input synchroniser and edge detector
module amdc_gpio_bank_sync #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_PINS-1:0] i_async,
  output logic [NUM_PINS-1:0] o_sync,
  output logic [NUM_PINS-1:0] o_rise,
  output logic [NUM_PINS-1:0] o_fall
);

  logic [NUM_PINS-1:0] r_chain [SYNC_STAGES];
  logic [NUM_PINS-1:0] r_sync_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
      r_sync_d <= '0;
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_sync_d <= r_chain[SYNC_STAGES-1];
    end
  end

  // Edges are combinational so status latches them one cycle after sync changes
  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_sync_d;
  assign o_fall = ~o_sync & r_sync_d;

endmodule

// File: rtl/amdc_gpio_bank.sv
// rtl/amdc_gpio_bank.sv - AXI4-Lite GPIO bank with edge capture and maskable interrupt
module amdc_gpio_bank
  import amdc_gpio_bank_pkg::*;
#(
  parameter int NUM_PINS             = 8,
  parameter int SYNC_STAGES          = 2,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [NUM_PINS-1:0]               gpio_in,
  output logic [NUM_PINS-1:0]               gpio_out,
  output logic [NUM_PINS-1:0]               gpio_oe,
  output logic                              irq
);

  wstate_e             r_wstate;
  rstate_e             r_rstate;
  logic                r_awready, r_bvalid, r_arready, r_rvalid, r_irq;
  logic [31:0]         r_rdata;
  logic [NUM_PINS-1:0] r_out, r_dir, r_irq_en, r_rise, r_fall;

  logic [NUM_PINS-1:0] w_sync, w_rise, w_fall, w_rise_clr, w_fall_clr;
  logic [31:0]         w_bmask, w_wr_data, w_rd_mux;
  logic [2:0]          w_waddr, w_raddr;
  logic                w_wr_fire, w_rd_fire;
  logic                w_unused;

  function automatic logic [31:0] zext(input logic [NUM_PINS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  amdc_gpio_bank_sync #(
    .NUM_PINS   (NUM_PINS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (s00_axi_aclk),
    .i_rst_n(s00_axi_aresetn),
    .i_async(gpio_in),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_waddr   = s00_axi_awaddr[4:2];
  assign w_raddr   = s00_axi_araddr[4:2];
  assign w_wr_fire = r_awready && s00_axi_awvalid && s00_axi_wvalid;
  assign w_rd_fire = r_arready && s00_axi_arvalid;
  assign w_bmask   = strb_mask(s00_axi_wstrb);
  assign w_wr_data = s00_axi_wdata & w_bmask;

  assign w_rise_clr = (w_wr_fire && w_waddr == REG_RISE) ? w_wr_data[NUM_PINS-1:0] : '0;
  assign w_fall_clr = (w_wr_fire && w_waddr == REG_FALL) ? w_wr_data[NUM_PINS-1:0] : '0;

  // Write channel: awready/wready pulse once when both address and data are offered
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_fire) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
            r_wstate  <= W_RESP;
          end else begin
            r_awready <= s00_axi_awvalid && s00_axi_wvalid;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_irq_en <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        case (w_waddr)
          REG_OUT:    r_out    <= (r_out    & ~w_bmask[NUM_PINS-1:0]) | w_wr_data[NUM_PINS-1:0];
          REG_DIR:    r_dir    <= (r_dir    & ~w_bmask[NUM_PINS-1:0]) | w_wr_data[NUM_PINS-1:0];
          REG_IRQ_EN: r_irq_en <= (r_irq_en & ~w_bmask[NUM_PINS-1:0]) | w_wr_data[NUM_PINS-1:0];
          default: ;
        endcase
      end
      // New edges are ORed after the clear so a coincident edge is never lost
      r_rise <= (r_rise & ~w_rise_clr) | w_rise;
      r_fall <= (r_fall & ~w_fall_clr) | w_fall;
      r_irq  <= |((r_rise | r_fall) & r_irq_en);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_raddr)
      REG_OUT:    w_rd_mux = zext(r_out);
      REG_DIR:    w_rd_mux = zext(r_dir);
      REG_IN:     w_rd_mux = zext(w_sync);
      REG_RISE:   w_rd_mux = zext(r_rise);
      REG_FALL:   w_rd_mux = zext(r_fall);
      REG_IRQ_EN: w_rd_mux = zext(r_irq_en);
      REG_CONFIG: w_rd_mux = {VERSION, 8'h00, 8'(NUM_PINS)};
      default:    w_rd_mux = '0;
    endcase
  end

  // Read data is captured at the address handshake, so a same-cycle write is not visible
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_fire) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_mux;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= s00_axi_arvalid;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            r_rvalid <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = RESP_OKAY;
  assign gpio_out        = r_out;
  assign gpio_oe         = r_dir;
  assign irq             = r_irq;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr,
                      w_bmask, w_wr_data};

endmodule
